// File: rtl/rcc_ker_clk_en_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rcc_ker_clk_pkg
// Brief   : Shared types and constants for the kernel clock-enable generator.
// Revision: 1.0 - initial release
// ============================================================================
package rcc_ker_clk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ch_state_e;

    // Shortest legal period; divisor values 0 and 1 are clamped up to this.
    localparam int DIV_MIN = 2;

endpackage : rcc_ker_clk_pkg
`default_nettype wire

// File: rtl/rcc_ker_clk_en_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : rcc_ker_clk_en_gen_if
// Brief   : Control/status bundle between a clock-control master and the
//           kernel clock-enable generator.
// Revision: 1.0 - initial release
// ============================================================================
interface rcc_ker_clk_en_gen_if #(
    parameter int CH_NUM   = 2,
    parameter int CORE_NUM = 2,
    parameter int DIV_W    = 6
);
    logic [CORE_NUM-1:0]        core_sleep;
    logic [CORE_NUM-1:0]        core_deepsleep;
    logic [CH_NUM*CORE_NUM-1:0] ch_en;
    logic [CH_NUM*CORE_NUM-1:0] ch_lpen;
    logic [CH_NUM*DIV_W-1:0]    div_fast;
    logic [CH_NUM*DIV_W-1:0]    div_slow;
    logic [CH_NUM-1:0]          speed_sel;
    logic [CH_NUM-1:0]          ch_div_clk;
    logic [CH_NUM-1:0]          ch_tick;
    logic [CH_NUM-1:0]          ch_active;
    logic [CH_NUM-1:0]          ch_switch_busy;

    modport master (
        output core_sleep, core_deepsleep, ch_en, ch_lpen,
               div_fast, div_slow, speed_sel,
        input  ch_div_clk, ch_tick, ch_active, ch_switch_busy
    );

    modport slave (
        input  core_sleep, core_deepsleep, ch_en, ch_lpen,
               div_fast, div_slow, speed_sel,
        output ch_div_clk, ch_tick, ch_active, ch_switch_busy
    );
endinterface : rcc_ker_clk_en_gen_if
`default_nettype wire

// File: rtl/rcc_ker_clk_en_gen_div_ch.sv
`default_nettype none
// ============================================================================
// Module  : rcc_ker_clk_div_ch
// Brief   : One kernel-clock channel: OFF/RUN/DRAIN FSM, period counter,
//           boundary-synchronous divisor reload and registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
module rcc_ker_clk_div_ch
    import rcc_ker_clk_pkg::*;
#(
    parameter int DIV_W = 6
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             i_req,
    input  wire [DIV_W-1:0] i_sel_div,
    output logic            o_div_clk,
    output logic            o_tick,
    output logic            o_active,
    output logic            o_busy
);

    localparam logic [DIV_W-1:0] C_DIV_MIN = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);

    ch_state_e        r_state_q, w_state_d;
    logic [DIV_W-1:0] r_cnt_q, w_cnt_d;
    logic [DIV_W-1:0] r_cur_div_q, w_cur_div_d;
    logic [DIV_W-1:0] w_sel_clamped;
    logic             r_div_clk_q, w_div_clk_d;
    logic             r_tick_q, w_tick_d;
    logic             r_busy_q, w_busy_d;
    logic             w_boundary;
    logic             w_running_d;

    assign w_sel_clamped = (i_sel_div < C_DIV_MIN) ? C_DIV_MIN : i_sel_div;
    assign w_boundary    = (r_cnt_q == (r_cur_div_q - C_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_OFF;
            r_cnt_q     <= '0;
            r_cur_div_q <= C_DIV_MIN;
            r_div_clk_q <= 1'b0;
            r_tick_q    <= 1'b0;
            r_busy_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_cur_div_q <= w_cur_div_d;
            r_div_clk_q <= w_div_clk_d;
            r_tick_q    <= w_tick_d;
            r_busy_q    <= w_busy_d;
        end
    end

    // A returning request in DRAIN takes priority over the boundary shutdown.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_OFF:   if (i_req)           w_state_d = ST_RUN;
            ST_RUN:   if (!i_req)          w_state_d = ST_DRAIN;
            ST_DRAIN: if (i_req)           w_state_d = ST_RUN;
                      else if (w_boundary) w_state_d = ST_OFF;
            default:                       w_state_d = ST_OFF;
        endcase
    end

    // Outputs are computed from next-state values so the registered copies
    // line up with the counter phase they describe.
    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_cur_div_d = r_cur_div_q;
        w_running_d = (w_state_d != ST_OFF);
        if (r_state_q == ST_OFF) begin
            w_cnt_d = '0;
            if (i_req) w_cur_div_d = w_sel_clamped;
        end else if (w_boundary) begin
            w_cnt_d     = '0;
            w_cur_div_d = w_sel_clamped;
        end else begin
            w_cnt_d = r_cnt_q + C_ONE;
        end
        w_div_clk_d = w_running_d && (w_cnt_d < (w_cur_div_d >> 1));
        w_tick_d    = w_running_d && (w_cnt_d == '0);
        w_busy_d    = w_running_d && (w_sel_clamped != w_cur_div_d);
    end

    assign o_div_clk = r_div_clk_q;
    assign o_tick    = r_tick_q;
    assign o_busy    = r_busy_q;
    assign o_active  = (r_state_q != ST_OFF);

endmodule : rcc_ker_clk_div_ch
`default_nettype wire

// File: rtl/rcc_ker_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module  : rcc_ker_clk_en_gen
// Brief   : Kernel clock-enable generator: per-channel core voting and
//           divisor selection feeding independent divider channels.
// Revision: 1.0 - initial release
// ============================================================================
module rcc_ker_clk_en_gen
    import rcc_ker_clk_pkg::*;
#(
    parameter int CH_NUM   = 2,
    parameter int CORE_NUM = 2,
    parameter int DIV_W    = 6
) (
    input  wire                  clk_in,
    input  wire                  sys_rst,
    rcc_ker_clk_en_gen_if.slave  bus
);

    logic [CH_NUM-1:0] w_div_clk;
    logic [CH_NUM-1:0] w_tick;
    logic [CH_NUM-1:0] w_active;
    logic [CH_NUM-1:0] w_busy;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [CORE_NUM-1:0] w_vote;
        logic [DIV_W-1:0]    w_sel_div;

        // A core keeps the channel alive unless it is asleep without
        // low-power enable, or in deepsleep regardless of lpen.
        for (genvar k = 0; k < CORE_NUM; k++) begin : g_core
            assign w_vote[k] = bus.ch_en[c*CORE_NUM+k]
                             & (~bus.core_sleep[k] | bus.ch_lpen[c*CORE_NUM+k])
                             & ~bus.core_deepsleep[k];
        end

        assign w_sel_div = bus.speed_sel[c] ? bus.div_fast[c*DIV_W +: DIV_W]
                                            : bus.div_slow[c*DIV_W +: DIV_W];

        rcc_ker_clk_div_ch #(
            .DIV_W (DIV_W)
        ) u_div_ch (
            .clk       (clk_in),
            .rst       (sys_rst),
            .i_req     (|w_vote),
            .i_sel_div (w_sel_div),
            .o_div_clk (w_div_clk[c]),
            .o_tick    (w_tick[c]),
            .o_active  (w_active[c]),
            .o_busy    (w_busy[c])
        );
    end

    assign bus.ch_div_clk     = w_div_clk;
    assign bus.ch_tick        = w_tick;
    assign bus.ch_active      = w_active;
    assign bus.ch_switch_busy = w_busy;

endmodule : rcc_ker_clk_en_gen
`default_nettype wire

// File: tb/tb_rcc_ker_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_rcc_ker_clk_en_gen
// Brief   : Directed self-checking bench for the kernel clock-enable generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rcc_ker_clk_en_gen;

    localparam int CH_NUM   = 2;
    localparam int CORE_NUM = 2;
    localparam int DIV_W    = 6;

    logic clk;
    logic sys_rst;
    int   checks;
    int   failures;

    rcc_ker_clk_en_gen_if #(
        .CH_NUM   (CH_NUM),
        .CORE_NUM (CORE_NUM),
        .DIV_W    (DIV_W)
    ) bus ();

    rcc_ker_clk_en_gen #(
        .CH_NUM   (CH_NUM),
        .CORE_NUM (CORE_NUM),
        .DIV_W    (DIV_W)
    ) dut (
        .clk_in  (clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.core_sleep     = '0;
        bus.core_deepsleep = '0;
        bus.ch_en          = '0;
        bus.ch_lpen        = '0;
        bus.div_fast       = '0;
        bus.div_slow       = '0;
        bus.speed_sel      = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.ch_en     = '1;
        bus.div_fast  = {6'd5, 6'd4};
        bus.speed_sel = '1;
        sys_rst       = 1'b1;
        step();
        step();
        for (int c = 0; c < CH_NUM; c++) begin
            checks++;
            if ({bus.ch_div_clk[c], bus.ch_tick[c], bus.ch_active[c], bus.ch_switch_busy[c]} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs ch=%0d got=%b exp=0000", c,
                         {bus.ch_div_clk[c], bus.ch_tick[c], bus.ch_active[c], bus.ch_switch_busy[c]});
            end
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_basic_run;
        logic exp_tick, exp_div;
        do_reset();
        bus.div_fast[5:0] = 6'd4;
        bus.speed_sel[0]  = 1'b1;
        bus.ch_en[0]      = 1'b1;
        checks++;
        if (bus.ch_active[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_active_before got=%b exp=0", bus.ch_active[0]);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            exp_tick = ((i % 4) == 0);
            exp_div  = ((i % 4) < 2);
            checks++;
            if ({bus.ch_tick[0], bus.ch_div_clk[0], bus.ch_active[0]} !== {exp_tick, exp_div, 1'b1}) begin
                failures++;
                $display("FAIL basic_run cyc=%0d got=%b exp=%b", i,
                         {bus.ch_tick[0], bus.ch_div_clk[0], bus.ch_active[0]}, {exp_tick, exp_div, 1'b1});
            end
            checks++;
            if (bus.ch_active[1] !== 1'b0) begin
                failures++;
                $display("FAIL basic_ch1_idle cyc=%0d got=%b exp=0", i, bus.ch_active[1]);
            end
            step();
        end
    endtask

    task automatic test_sleep_gating;
        logic [2:0] exp_vec [3];
        exp_vec[0] = 3'b100;
        exp_vec[1] = 3'b100;
        exp_vec[2] = 3'b000;
        do_reset();
        bus.div_fast[5:0] = 6'd4;
        bus.speed_sel[0]  = 1'b1;
        bus.ch_en[0]      = 1'b1;
        step();
        step();
        bus.core_sleep[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.ch_active[0], bus.ch_tick[0], bus.ch_div_clk[0]} !== exp_vec[i]) begin
                failures++;
                $display("FAIL sleep_drain step=%0d got=%b exp=%b", i,
                         {bus.ch_active[0], bus.ch_tick[0], bus.ch_div_clk[0]}, exp_vec[i]);
            end
        end
        do_reset();
        bus.div_fast[5:0] = 6'd4;
        bus.speed_sel[0]  = 1'b1;
        bus.ch_en[0]      = 1'b1;
        bus.ch_lpen[0]    = 1'b1;
        step();
        step();
        bus.core_sleep[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({bus.ch_active[0], bus.ch_tick[0]} !== {1'b1, ((i + 1) % 4) == 0}) begin
                failures++;
                $display("FAIL sleep_lpen step=%0d got=%b exp=%b", i,
                         {bus.ch_active[0], bus.ch_tick[0]}, {1'b1, ((i + 1) % 4) == 0});
            end
        end
    endtask

    task automatic test_ratio_switch;
        logic [2:0] exp;
        do_reset();
        bus.div_slow[5:0] = 6'd20;
        bus.div_fast[5:0] = 6'd2;
        bus.speed_sel[0]  = 1'b0;
        bus.ch_en[0]      = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        bus.speed_sel[0] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k <= 14) exp = {1'b1, 1'b0, (5 + k) < 10};
            else         exp = {1'b0, (k % 2) == 1, (k % 2) == 1};
            checks++;
            if ({bus.ch_switch_busy[0], bus.ch_tick[0], bus.ch_div_clk[0]} !== exp) begin
                failures++;
                $display("FAIL ratio_switch step=%0d got=%b exp=%b", k,
                         {bus.ch_switch_busy[0], bus.ch_tick[0], bus.ch_div_clk[0]}, exp);
            end
        end
    endtask

    task automatic test_drain_abort;
        do_reset();
        bus.div_fast[5:0] = 6'd6;
        bus.speed_sel[0]  = 1'b1;
        bus.ch_en[0]      = 1'b1;
        step();
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if ({bus.ch_active[0], bus.ch_tick[0]} !== {1'b1, (i % 6) == 0}) begin
                failures++;
                $display("FAIL drain_abort step=%0d got=%b exp=%b", i,
                         {bus.ch_active[0], bus.ch_tick[0]}, {1'b1, (i % 6) == 0});
            end
            if (i == 1) bus.ch_en[0] = 1'b0;
            if (i == 4) bus.ch_en[0] = 1'b1;
        end
    endtask

    task automatic test_multicore;
        logic [1:0] exp_vec [3];
        exp_vec[0] = 2'b10;
        exp_vec[1] = 2'b10;
        exp_vec[2] = 2'b00;
        do_reset();
        bus.div_fast[5:0]  = 6'd3;
        bus.speed_sel[0]   = 1'b1;
        bus.ch_en[1:0]     = 2'b11;
        bus.core_deepsleep = 2'b01;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.ch_active[0], bus.ch_tick[0], bus.ch_div_clk[0]} !== {1'b1, (i % 3) == 0, (i % 3) == 0}) begin
                failures++;
                $display("FAIL multicore_run cyc=%0d got=%b exp=%b", i,
                         {bus.ch_active[0], bus.ch_tick[0], bus.ch_div_clk[0]}, {1'b1, (i % 3) == 0, (i % 3) == 0});
            end
            if (i < 3) step();
        end
        bus.core_deepsleep = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.ch_active[0], bus.ch_tick[0]} !== exp_vec[i]) begin
                failures++;
                $display("FAIL multicore_drain step=%0d got=%b exp=%b", i,
                         {bus.ch_active[0], bus.ch_tick[0]}, exp_vec[i]);
            end
        end
    endtask

    task automatic test_clamp_reset;
        do_reset();
        bus.div_fast[5:0]  = 6'd0;
        bus.speed_sel[0]   = 1'b1;
        bus.ch_en[0]       = 1'b1;
        bus.div_slow[11:6] = 6'd20;
        bus.div_fast[11:6] = 6'd4;
        bus.speed_sel[1]   = 1'b0;
        bus.ch_en[2]       = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.ch_tick[0], bus.ch_div_clk[0], bus.ch_switch_busy[0]} !== {(i % 2) == 0, (i % 2) == 0, 1'b0}) begin
                failures++;
                $display("FAIL clamp_div0 cyc=%0d got=%b exp=%b", i,
                         {bus.ch_tick[0], bus.ch_div_clk[0], bus.ch_switch_busy[0]}, {(i % 2) == 0, (i % 2) == 0, 1'b0});
            end
            if (i == 1) bus.speed_sel[1] = 1'b1;
            step();
        end
        checks++;
        if ({bus.ch_active[1], bus.ch_switch_busy[1], bus.ch_tick[1]} !== 3'b110) begin
            failures++;
            $display("FAIL ch1_busy_pre_reset got=%b exp=110",
                     {bus.ch_active[1], bus.ch_switch_busy[1], bus.ch_tick[1]});
        end
        sys_rst = 1'b1;
        step();
        for (int c = 0; c < CH_NUM; c++) begin
            checks++;
            if ({bus.ch_div_clk[c], bus.ch_tick[c], bus.ch_active[c], bus.ch_switch_busy[c]} !== 4'b0000) begin
                failures++;
                $display("FAIL midperiod_reset ch=%0d got=%b exp=0000", c,
                         {bus.ch_div_clk[c], bus.ch_tick[c], bus.ch_active[c], bus.ch_switch_busy[c]});
            end
        end
        sys_rst = 1'b0;
        step();
        checks++;
        if ({bus.ch_active[1], bus.ch_tick[1], bus.ch_switch_busy[1]} !== 3'b110) begin
            failures++;
            $display("FAIL restart_after_reset got=%b exp=110",
                     {bus.ch_active[1], bus.ch_tick[1], bus.ch_switch_busy[1]});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sys_rst  = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_run();
        test_sleep_gating();
        test_ratio_switch();
        test_drain_abort();
        test_multicore();
        test_clamp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rcc_ker_clk_en_gen
`default_nettype wire

// File: doc/rcc_ker_clk_en_gen.md
Name: rcc_ker_clk_en_gen

Overview:
- Parametrised single-clock kernel-clock controller: replaces per-peripheral pad-clock dividers, muxes and gates with clock-enable generation in the kernel clock domain.
- Each of CH_NUM channels produces a divided 50%-style level and a one-cycle tick.
- Each channel selects one of two programmable divisors, the fast/slow speed select being the generalisation of the fes mux.
- Ratio changes apply only at period boundaries. Gating follows per-core sleep/deepsleep with drain-to-boundary shutdown.

Parameters:
- CH_NUM, 2, number of independent channels
- CORE_NUM, 2, number of cores voting on each channel
- DIV_W, 6, divisor width; legal period 2..2^DIV_W-1 cycles

Ports:
- clk_in  input  1  kernel clock
- sys_rst  input  1  synchronous reset, active-high
- core_sleep  input  CORE_NUM  per-core sleep
- core_deepsleep  input  CORE_NUM  per-core deepsleep
- ch_en  input  CH_NUM*CORE_NUM  enable; bit [c*CORE_NUM+k] = channel c, core k
- ch_lpen  input  CH_NUM*CORE_NUM  low-power enable, same packing
- div_fast  input  CH_NUM*DIV_W  fast-mode period per channel
- div_slow  input  CH_NUM*DIV_W  slow-mode period per channel
- speed_sel  input  CH_NUM  1 = fast divisor, 0 = slow divisor
- ch_div_clk  output  CH_NUM  divided level
- ch_tick  output  CH_NUM  one-cycle pulse at period start
- ch_active  output  CH_NUM  channel not in OFF
- ch_switch_busy  output  CH_NUM  divisor change pending

Behaviour:
- Request per channel: req[c] = OR over k of (ch_en & (~core_sleep[k] | ch_lpen) & ~core_deepsleep[k]). Purely combinational.
- Selected divisor: sel_div = speed_sel ? div_fast : div_slow. Values 0 and 1 are clamped to 2.
- Active divisor cur_div is a register. It is loaded only on the cycle when cnt == cur_div-1 or when leaving OFF.
- Counter cnt runs 0..cur_div-1 and wraps to 0.
- Outputs are registered:
  - ch_div_clk = (cnt < cur_div>>1), e.g. D=4 gives 1100, D=3 gives 100.
  - ch_tick = (cnt == 0).
  - Both are forced 0 in OFF.
- Per-channel FSM states: OFF, RUN, DRAIN.
  - OFF: cnt = 0, outputs 0. On req = 1, next edge goes to RUN with cnt = 0 and cur_div = sel_div. First tick and div_clk-high appear one cycle after req is sampled high.
  - RUN: if req = 0, go to DRAIN; counting continues.
  - DRAIN: counting continues. At cnt == cur_div-1, go to OFF; the next cycle outputs are 0. If req returns to 1 before the boundary, go back to RUN with no gap and no phase disturbance.
  - Simultaneous req re-assert and boundary in DRAIN: RUN wins; the period wraps normally.
- ch_switch_busy = (state != OFF) & (sel_div_clamped != cur_div), registered. It clears the cycle after the boundary that loads the new divisor. A value that changes again before the boundary is loaded as its last value. Mid-period changes never shorten or stretch the current period.
- ch_active = (state != OFF).
- Reset (sys_rst = 1 at an edge) gives:
  - all states OFF, cnt = 0, cur_div = 2
  - all outputs 0
- Reset mid-period aborts immediately with no drain.
- Channels are fully independent. No cross-channel ordering.

Decomposition:
- Package rcc_ker_clk_pkg holds the state enum (OFF/RUN/DRAIN, 2 bits) and DIV_MIN = 2 constant.
- Sub-module rcc_ker_clk_div_ch holds one channel: FSM, counter, cur_div, outputs. It is instantiated CH_NUM times via generate.
- The top level computes req and slices the packed buses.

Test Plan:
- Basic run: ch0 core0 en = 1, sleep = 0, speed_sel = 1, div_fast = 4. Required: tick every 4 cycles; div_clk pattern 1100 repeating; active = 1 one cycle after en.
- Sleep gating: core0 sleep = 1 with lpen = 0 at cnt = 1, D = 4. Required: active stays 1 through cnt = 3, then OFF; outputs 0 from the next cycle. Repeat with lpen = 1: no shutdown.
- Ratio switch: D = 20 slow → set speed_sel = 1 (fast = 2) at cnt = 5. Required: busy = 1 until cnt = 19; the 20-cycle period completes; then period = 2; busy = 0 after the boundary.
- Drain abort: req drops at cnt = 1 of D = 6, returns at cnt = 4. Required: no missing tick; active never drops; tick spacing stays 6.
- Multi-core OR: core0 deepsleep = 1, core1 en = 1 awake. Required: channel runs. Both cores deepsleep → drains to OFF.
- Clamp/reset: div = 0 gives period 2. sys_rst asserted mid-period gives all outputs 0 next cycle, cur_div = 2, busy = 0.
